multicycle_control: RTL and testbench

Multi-cycle sequencer for the MIPS core, replacing the single-cycle opcode decoder. It steps the shared datapath (one memory, one ALU, IR/MDR/A/B/ALUOut registers) through fetch, decode, execute, memory and writeback. It stalls memory states on a ready handshake and reports instruction completion and illegal opcodes. Opcode comes from the instruction register and is stable from DECODE until the next FETCH completes.

---
 rtl/mips_pkg.sv | 77 +++++++
 rtl/multicycle_control.sv | 153 +++++++++++++++
 tb/tb_multicycle_control.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, datapath mux codes, sequencer states.
// Used by both the single-cycle decoder and the multi-cycle sequencer.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_R    = 6'b000000;
    localparam opcode_t OP_ADDI = 6'b001000;
    localparam opcode_t OP_LW   = 6'b100011;
    localparam opcode_t OP_SW   = 6'b101011;
    localparam opcode_t OP_BEQ  = 6'b000100;
    localparam opcode_t OP_BNE  = 6'b000101;
    localparam opcode_t OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_EXEC_I  = 4'd5,
        S_WB_I    = 4'd6,
        S_MEM_ADR = 4'd7,
        S_MEM_RD  = 4'd8,
        S_WB_MEM  = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    // Datapath control word driven by the sequencer each cycle.
    typedef struct packed {
        logic       pc_write;
        logic [1:0] branch_op;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal(input opcode_t op);
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps the shared datapath through fetch, decode,
// execute, memory and writeback, stalling memory states on mem_ready.
module multicycle_control
    import mips_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic [1:0]          BranchOp,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state_dbg
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:    state_next = S_FETCH;
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:         state_next = S_EXEC_R;
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_MEM_ADR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_EXEC_R:  state_next = S_WB_R;
            S_WB_R:    state_next = S_FETCH;
            S_EXEC_I:  state_next = S_WB_I;
            S_WB_I:    state_next = S_FETCH;
            S_MEM_ADR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_WB_MEM:  state_next = S_FETCH;
            S_MEM_WR:  state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_BRANCH:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    // Control word decode from the current state.
    always_comb begin
        ctrl           = '0;
        ctrl.branch_op = BR_NONE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~is_legal(opcode);
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_EXEC_I, S_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_WB_I: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.branch_op  = (opcode == OP_BNE) ? BR_NE : BR_EQ;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = ctrl.pc_write;
    assign BranchOp   = ctrl.branch_op;
    assign IorD       = ctrl.i_or_d;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegDst     = ctrl.reg_dst;
    assign RegWrite   = ctrl.reg_write;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign ALUOp      = ctrl.alu_op;
    assign PCSource   = ctrl.pc_source;
    assign instr_done = ctrl.instr_done;
    assign illegal_op = ctrl.illegal_op;
    assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle control words and
// per-instruction cycle counts are queued by the driver and checked by a monitor.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clock;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] BranchOp, ALUSrcB, ALUOp, PCSource;
    logic       instr_done, illegal_op;
    logic [3:0] state_dbg;

    multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .BranchOp(BranchOp), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       pcwrite;
        logic [1:0] branchop;
        logic       iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, aluop, pcsource;
        logic       done, illegal;
        logic [3:0] st;
    } obs_t;

    obs_t obs;
    assign obs = {PCWrite, BranchOp, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, illegal_op, state_dbg};

    obs_t exp_q[$];
    int   len_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    int   cnt    = 0;
    logic first_cyc = 1'b0;
    logic end_req   = 1'b0;
    logic end_done  = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b001000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000101 || op == 6'b000010;
    endfunction

    // Control values each state presents, straight from the state table.
    function automatic obs_t model(input state_t s, input logic [5:0] op, input logic rdy);
        obs_t o;
        o = '0;
        o.st = 4'(s);
        case (s)
            S_FETCH:  begin o.memread = 1; o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
            S_DECODE: begin o.alusrcb = 2'b11; o.illegal = !legal(op); end
            S_EXEC_R: begin o.alusrca = 1; o.aluop = 2'b10; end
            S_WB_R:   begin o.regdst = 1; o.regwrite = 1; o.done = 1; end
            S_EXEC_I, S_MEM_ADR: begin o.alusrca = 1; o.alusrcb = 2'b10; end
            S_WB_I:   begin o.regwrite = 1; o.done = 1; end
            S_MEM_RD: begin o.memread = 1; o.iord = 1; end
            S_WB_MEM: begin o.memtoreg = 1; o.regwrite = 1; o.done = 1; end
            S_MEM_WR: begin o.memwrite = 1; o.iord = 1; o.done = rdy; end
            S_BRANCH: begin
                o.alusrca = 1; o.aluop = 2'b01; o.pcsource = 2'b01; o.done = 1;
                o.branchop = (op == 6'b000101) ? 2'b10 : 2'b01;
            end
            S_JUMP:   begin o.pcwrite = 1; o.pcsource = 2'b10; o.done = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b101011: return 4;
            6'b100011:                       return 5;
            6'b000100, 6'b000101, 6'b000010: return 3;
            default:                         return 2;
        endcase
    endfunction

    task automatic cyc(input state_t s, input logic [5:0] op, input logic rdy,
                       input logic rst, input logic first);
        @(posedge clock);
        #1;
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        first_cyc = first;
        exp_q.push_back(model(s, op, rdy));
    endtask

    // Expand one instruction into its cycle-by-cycle state walk and drive it.
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
        state_t st[$];
        bit     rd[$];
        int     len;
        for (int i = 0; i < sf; i++) begin st.push_back(S_FETCH); rd.push_back(1'b0); end
        st.push_back(S_FETCH);  rd.push_back(1'b1);
        st.push_back(S_DECODE); rd.push_back(1'($urandom_range(0, 1)));
        len = base_cycles(op) + sf;
        case (op)
            6'b000000: begin st.push_back(S_EXEC_R); st.push_back(S_WB_R); end
            6'b001000: begin st.push_back(S_EXEC_I); st.push_back(S_WB_I); end
            6'b100011: begin
                st.push_back(S_MEM_ADR);
                for (int i = 0; i <= sm; i++) st.push_back(S_MEM_RD);
                st.push_back(S_WB_MEM);
                len += sm;
            end
            6'b101011: begin
                st.push_back(S_MEM_ADR);
                for (int i = 0; i <= sm; i++) st.push_back(S_MEM_WR);
                len += sm;
            end
            6'b000100, 6'b000101: st.push_back(S_BRANCH);
            6'b000010:            st.push_back(S_JUMP);
            default: ;
        endcase
        while (rd.size() < st.size()) begin
            state_t s;
            int     k;
            s = st[rd.size()];
            if (s == S_MEM_RD || s == S_MEM_WR) begin
                k = 0;
                for (int j = 0; j < rd.size(); j++) if (st[j] == s) k++;
                rd.push_back(k >= sm);
            end else begin
                rd.push_back(1'($urandom_range(0, 1)));
            end
        end
        len_q.push_back(len);
        for (int i = 0; i < st.size(); i++) cyc(st[i], op, rd[i], 1'b0, i == 0);
    endtask

    // Monitor: compare every cycle, and the instruction length at each completion pulse.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            cyc_no++;
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ctrl cycle %0d: actual=%h required=%h (state actual %0d required %0d)",
                         cyc_no, obs, e, obs.st, e.st);
            end
            cnt = first_cyc ? 1 : cnt + 1;
            if (instr_done === 1'b1 || illegal_op === 1'b1) begin
                checks++;
                if (len_q.size() == 0) begin
                    errors++;
                    $display("FAIL len cycle %0d: unexpected completion pulse, no instruction pending", cyc_no);
                end else begin
                    int l;
                    l = len_q.pop_front();
                    if (cnt != l) begin
                        errors++;
                        $display("FAIL len cycle %0d: actual=%0d cycles required=%0d", cyc_no, cnt, l);
                    end
                end
            end
        end else if (end_req && !end_done) begin
            checks++;
            if (len_q.size() != 0) begin
                errors++;
                $display("FAIL drain: actual=%0d instructions never completed required=0", len_q.size());
            end
            end_done <= 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 6'b0;
        mem_ready = 1'b0;
        cyc(S_IDLE, 6'b0, 1'b0, 1'b1, 1'b0);
        cyc(S_IDLE, 6'b0, 1'b0, 1'b0, 1'b0);

        // add, addi, lw, sw, beq, j with no stalls
        run_instr(6'b000000, 0, 0);
        run_instr(6'b001000, 0, 0);
        run_instr(6'b100011, 0, 0);
        run_instr(6'b101011, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        // stalled lw, bne, illegal, stalled sw
        run_instr(6'b100011, 2, 3);
        run_instr(6'b000101, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b101011, 0, 4);

        // reset held 3 cycles while lw stalls in MEM_RD
        cyc(S_FETCH,   6'b100011, 1'b1, 1'b0, 1'b0);
        cyc(S_DECODE,  6'b100011, 1'b1, 1'b0, 1'b0);
        cyc(S_MEM_ADR, 6'b100011, 1'b1, 1'b0, 1'b0);
        cyc(S_MEM_RD,  6'b100011, 1'b0, 1'b1, 1'b0);
        cyc(S_IDLE,    6'b100011, 1'b0, 1'b1, 1'b0);
        cyc(S_IDLE,    6'b100011, 1'b0, 1'b1, 1'b0);
        cyc(S_IDLE,    6'b100011, 1'b0, 1'b0, 1'b0);
        run_instr(6'b000000, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b001000;
                2: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b000101;
                6: op = 6'b000010;
                default: begin
                    op = 6'($urandom);
                    while (legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        @(posedge clock);
        #1;
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(negedge clock);
        if (!end_done) begin
            $display("FAIL drain: monitor never finished");
            $fatal(1, "drain");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
